gf180mcu_fd_sc_mcu9t5v0__aoi21_bist: RTL and testbench

Built-in self-test sequencer for the aoi21 cell. It drives the cell's three inputs through an exhaustive vector sweep, waits a programmable settle time, samples ZN and compares it against a golden AOI21 function. It also counts mismatches and records the first failing vector. It sits on the driving and observing side of a cell under test in characterization and silicon-debug harnesses.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_pkg.sv | 19 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_golden.sv | 13 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv | 132 +++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_pkg.sv
// Shared types and the golden AOI21 function for the aoi21 BIST sequencer
// and any bench that needs the reference response.
package gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_pkg;

    localparam int VEC_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // v = {A1, A2, B}
    function automatic logic aoi21_exp(input logic [VEC_W-1:0] v);
        return ~((v[2] & v[1]) | v[0]);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_golden.sv
// Combinational golden AOI21 model: ZN_exp = ~((A1 & A2) | B).
module gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_golden
    import gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_pkg::*;
(
    input  logic A1,
    input  logic A2,
    input  logic B,
    output logic ZN_exp
);

    assign ZN_exp = aoi21_exp({A1, A2, B});

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv
// Exhaustive-sweep BIST sequencer for an aoi21 cell: drives A1/A2/B, waits
// SETTLE cycles, samples ZN against the golden function and logs mismatches.
module gf180mcu_fd_sc_mcu9t5v0__aoi21_bist
    import gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int PASSES = 1,
    parameter int ERRW   = 4
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            START,
    output logic            A1,
    output logic            A2,
    output logic            B,
    input  logic            ZN,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic [ERRW-1:0] ERR_CNT,
    output logic            FAIL_VLD,
    output logic [2:0]      FAIL_VEC
);

    localparam logic [3:0]      SETTLE_L  = 4'(SETTLE);
    localparam logic [7:0]      LAST_PASS = 8'(PASSES - 1);
    localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};
    // With no settle time each new vector goes straight to its sample cycle.
    localparam state_t          FIRST_ST  = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;

    state_t            state_q, state_d;
    logic [3:0]        set_cnt_q, set_cnt_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [7:0]        pass_q, pass_d;
    logic [ERRW-1:0]   err_q, err_d;
    logic              fail_vld_q, fail_vld_d;
    logic [VEC_W-1:0]  fail_vec_q, fail_vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              zn_exp;

    gf180mcu_fd_sc_mcu9t5v0__aoi21_bist_golden u_golden (
        .A1     (vec_q[2]),
        .A2     (vec_q[1]),
        .B      (vec_q[0]),
        .ZN_exp (zn_exp)
    );

    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        vec_d      = vec_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d    = FIRST_ST;
                    set_cnt_d  = 4'd0;
                    vec_d      = '0;
                    pass_d     = 8'd0;
                    err_d      = '0;
                    fail_vld_d = 1'b0;
                    fail_vec_d = '0;
                end
            end
            ST_WAIT: begin
                if (set_cnt_q == SETTLE_L - 4'd1) begin
                    state_d   = ST_SAMPLE;
                    set_cnt_d = 4'd0;
                end else begin
                    set_cnt_d = set_cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (ZN != zn_exp) begin
                    if (err_q != ERR_MAX) err_d = err_q + ERRW'(1);
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_vec_d = vec_q;
                    end
                end
                if (vec_q == 3'd7 && pass_q == LAST_PASS) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d     = vec_q + 3'd1;
                    set_cnt_d = 4'd0;
                    state_d   = FIRST_ST;
                    if (vec_q == 3'd7) pass_d = pass_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q    <= ST_IDLE;
            set_cnt_q  <= 4'd0;
            vec_q      <= '0;
            pass_q     <= 8'd0;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_cnt_q  <= set_cnt_d;
            vec_q      <= vec_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign {A1, A2, B} = vec_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign PASS        = done_q && (err_q == '0);
    assign ERR_CNT     = err_q;
    assign FAIL_VLD    = fail_vld_q;
    assign FAIL_VEC    = fail_vec_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi21_bist.sv
// Bench for the aoi21 BIST sequencer: three parameterisations driven against
// an ideal or stuck-at cell model, with a pin-trace and result scoreboard.
module tb_gf180mcu_fd_sc_mcu9t5v0__aoi21_bist;

    logic       clk = 1'b0;
    logic [2:0] rn;
    logic [2:0] start;
    logic [2:0] zn;
    int         zmode [3];

    wire  [2:0] a1, a2, b, busy, done, pass, fvld;
    wire  [3:0] err0, err1;
    wire  [1:0] err2;
    wire  [2:0] fvec0, fvec1, fvec2;

    int errors = 0;
    int checks = 0;

    logic [2:0]  trace_q [$];
    logic [13:0] res_q   [$];

    always #5 clk = ~clk;

    // Cell model: 0 = ideal AOI21, 1 = ZN stuck at 0, 2 = ZN stuck at 1
    always_comb begin
        zn = '0;
        for (int i = 0; i < 3; i++) begin
            if (zmode[i] == 0)      zn[i] = ~((a1[i] & a2[i]) | b[i]);
            else if (zmode[i] == 1) zn[i] = 1'b0;
            else                    zn[i] = 1'b1;
        end
    end

    gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(.SETTLE(1), .PASSES(1), .ERRW(4)) dut0 (
        .CLK(clk), .RN(rn[0]), .START(start[0]), .A1(a1[0]), .A2(a2[0]), .B(b[0]),
        .ZN(zn[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
        .ERR_CNT(err0), .FAIL_VLD(fvld[0]), .FAIL_VEC(fvec0));

    gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(.SETTLE(0), .PASSES(1), .ERRW(4)) dut1 (
        .CLK(clk), .RN(rn[1]), .START(start[1]), .A1(a1[1]), .A2(a2[1]), .B(b[1]),
        .ZN(zn[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
        .ERR_CNT(err1), .FAIL_VLD(fvld[1]), .FAIL_VEC(fvec1));

    gf180mcu_fd_sc_mcu9t5v0__aoi21_bist #(.SETTLE(2), .PASSES(2), .ERRW(2)) dut2 (
        .CLK(clk), .RN(rn[2]), .START(start[2]), .A1(a1[2]), .A2(a2[2]), .B(b[2]),
        .ZN(zn[2]), .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]),
        .ERR_CNT(err2), .FAIL_VLD(fvld[2]), .FAIL_VEC(fvec2));

    // {pins[2:0], busy, done, pass, fail_vld, fail_vec[2:0], err_cnt[3:0]}
    function automatic logic [13:0] snap(input int d);
        logic [2:0] fv;
        logic [3:0] ec;
        case (d)
            0:       begin fv = fvec0; ec = err0;          end
            1:       begin fv = fvec1; ec = err1;          end
            default: begin fv = fvec2; ec = {2'b00, err2}; end
        endcase
        return {a1[d], a2[d], b[d], busy[d], done[d], pass[d], fvld[d], fv, ec};
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int d, input int settle, input int passes, input int errmax,
                       input int mode, input bit hold, input int abort_at);
        int         ecnt;
        bit         fv;
        logic [2:0] fvec;
        logic [2:0] v;
        logic [2:0] p;
        logic       ex, zm;
        logic [13:0] r;
        int         n;
        zmode[d] = mode;
        ecnt = 0; fv = 1'b0; fvec = 3'd0;
        for (int ps = 0; ps < passes; ps++) begin
            for (int vi = 0; vi < 8; vi++) begin
                v = 3'(vi);
                for (int c = 0; c <= settle; c++) trace_q.push_back(v);
                ex = ~((v[2] & v[1]) | v[0]);
                zm = (mode == 0) ? ex : (mode == 1) ? 1'b0 : 1'b1;
                if (zm != ex) begin
                    if (ecnt < errmax) ecnt++;
                    if (!fv) begin fv = 1'b1; fvec = v; end
                end
            end
        end
        res_q.push_back({3'd7, 1'b0, 1'b1, (ecnt == 0), fv, fvec, 4'(ecnt)});
        n = trace_q.size();

        @(negedge clk) start[d] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            #1;
            if (!hold) start[d] = 1'b0;
            if (abort_at > 0 && k == abort_at) begin
                @(negedge clk) rn[d] = 1'b0;
                @(posedge clk);
                #1 check("reset_mid_run", snap(d), 14'd0);
                rn[d] = 1'b1;
                trace_q.delete();
                res_q.delete();
                return;
            end
            p = trace_q.pop_front();
            check("pin_trace", {9'd0, snap(d)[13:9]}, {9'd0, p, 1'b1, 1'b0});
            @(posedge clk);
        end
        #1;
        r = res_q.pop_front();
        check("done_result", snap(d), r);
        if (!hold) begin
            @(posedge clk);
            #1 check("done_held", snap(d), r);
        end
    endtask

    initial begin
        rn = 3'b000;
        start = 3'b000;
        for (int i = 0; i < 3; i++) zmode[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check("reset_state", snap(d), 14'd0);
        rn = 3'b111;

        run(0, 1, 1, 15, 0, 1'b0, 0);   // ideal cell, defaults
        run(0, 1, 1, 15, 1, 1'b0, 0);   // ZN stuck at 0
        run(0, 1, 1, 15, 2, 1'b0, 0);   // ZN stuck at 1
        run(2, 2, 2, 3,  2, 1'b0, 0);   // saturating 2-bit counter, two passes
        run(1, 0, 1, 15, 0, 1'b0, 0);   // zero settle time
        run(0, 1, 1, 15, 1, 1'b1, 0);   // START held through run, restarts from DONE
        run(0, 1, 1, 15, 0, 1'b0, 0);   // restart clears the errors
        run(0, 1, 1, 15, 1, 1'b0, 5);   // reset mid-run
        run(0, 1, 1, 15, 0, 1'b0, 0);   // clean sweep after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
